// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// i2c_seq_pkg : shared types and defaults for the I2C register sequencer (rev 1.0)
// ============================================================================
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_WAIT_READY = 4'd1,
    S_ADDR_W     = 4'd2,
    S_REG        = 4'd3,
    S_DATA_W     = 4'd4,
    S_ADDR_R     = 4'd5,
    S_DATA_R     = 4'd6,
    S_DONE       = 4'd7,
    S_ERR        = 4'd8
  } state_e;

  // R/W bit appended to the 7-bit device address
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

  localparam logic [6:0]  DEF_DEV_ADDR  = 7'h77;
  localparam int          DEF_MAX_BYTES = 22;
  localparam logic [15:0] DEF_TIMEOUT   = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/i2c_seq_buffer.sv
`default_nettype none
// ============================================================================
// i2c_seq_buffer : DEPTH x 8 register file, async clear, 1 write / 2 read ports (rev 1.0)
// ============================================================================
module i2c_seq_buffer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_BYTES,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] mem_q [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mem_q[g] <= 8'h00;
      end else if (we_i && (waddr_i == AW'(g))) begin
        mem_q[g] <= wdata_i;
      end
    end
  end

  // Address decode by comparison so out-of-range addresses read back as 0
  always_comb begin
    rdata_a_o = 8'h00;
    rdata_b_o = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a_i == AW'(i)) rdata_a_o = mem_q[i];
      if (raddr_b_i == AW'(i)) rdata_b_o = mem_q[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// i2c_reg_sequencer : register read/write burst sequencer for a byte-level I2C master (rev 1.0)
// ============================================================================
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = DEF_DEV_ADDR,
  parameter int          MAX_BYTES = DEF_MAX_BYTES,
  parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT,
  parameter int          LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [7:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             buf_wr_en,
  input  logic [LEN_W-1:0] buf_wr_addr,
  input  logic [7:0]       buf_wr_data,
  input  logic [LEN_W-1:0] buf_rd_addr,
  output logic [7:0]       buf_rd_data,
  output logic             done,
  output logic             error,
  input  logic             isReady,
  output logic             start,
  output logic             send,
  output logic [7:0]       datasend,
  input  logic             sended,
  output logic             receive,
  output logic             last,
  input  logic [7:0]       datareceive,
  input  logic             received
);

  state_e            state_q, state_d;
  logic              write_q;
  logic [7:0]        reg_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [15:0]       timer_q, timer_d;

  logic              w_accept;
  logic              w_reject;
  logic              w_last_idx;
  logic              w_timeout;
  logic              w_hs;
  logic              w_phase;
  logic              w_fsm_we;
  logic              w_buf_we;
  logic [LEN_W-1:0]  w_buf_waddr;
  logic [7:0]        w_buf_wdata;
  logic [7:0]        w_buf_idx_data;

  assign w_accept   = (state_q == S_IDLE) && cmd_valid;
  assign w_reject   = (len_q > LEN_W'(MAX_BYTES)) || (!write_q && (len_q == '0));
  assign w_last_idx = (idx_q == (len_q - LEN_W'(1)));
  assign w_timeout  = (timer_q == (TIMEOUT - 16'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      reg_q   <= 8'h00;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      if (w_accept) begin
        write_q <= cmd_write;
        reg_q   <= cmd_reg;
        len_q   <= cmd_len;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    start     = 1'b0;
    send      = 1'b0;
    receive   = 1'b0;
    last      = 1'b0;
    datasend  = 8'h00;
    w_hs      = 1'b0;
    w_phase   = 1'b0;
    w_fsm_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = S_WAIT_READY;
          idx_d   = '0;
          w_hs    = 1'b1;
        end
      end
      S_WAIT_READY: begin
        // Bad commands are bounced from here so the host sees a uniform latency
        if (w_reject) begin
          state_d = S_ERR;
        end else begin
          w_phase = 1'b1;
          if (isReady) begin
            state_d = S_ADDR_W;
            w_hs    = 1'b1;
          end
        end
      end
      S_ADDR_W: begin
        w_phase  = 1'b1;
        start    = 1'b1;
        send     = 1'b1;
        datasend = {DEV_ADDR, I2C_WRITE};
        if (sended) begin
          state_d = S_REG;
          w_hs    = 1'b1;
        end
      end
      S_REG: begin
        w_phase  = 1'b1;
        send     = 1'b1;
        datasend = reg_q;
        last     = write_q && (len_q == '0);
        if (sended) begin
          w_hs = 1'b1;
          if (!write_q)            state_d = S_ADDR_R;
          else if (len_q == '0)    state_d = S_DONE;
          else                     state_d = S_DATA_W;
        end
      end
      S_DATA_W: begin
        w_phase  = 1'b1;
        send     = 1'b1;
        datasend = w_buf_idx_data;
        last     = w_last_idx;
        if (sended) begin
          w_hs  = 1'b1;
          idx_d = idx_q + LEN_W'(1);
          if (w_last_idx) state_d = S_DONE;
        end
      end
      S_ADDR_R: begin
        w_phase  = 1'b1;
        start    = 1'b1;
        send     = 1'b1;
        datasend = {DEV_ADDR, I2C_READ};
        if (sended) begin
          state_d = S_DATA_R;
          w_hs    = 1'b1;
        end
      end
      S_DATA_R: begin
        w_phase = 1'b1;
        receive = 1'b1;
        last    = w_last_idx;
        if (received) begin
          w_hs     = 1'b1;
          w_fsm_we = 1'b1;
          idx_d    = idx_q + LEN_W'(1);
          if (w_last_idx) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Any handshake restarts the watchdog; otherwise it counts while a phase waits
    if (w_hs) begin
      timer_d = 16'd0;
    end else if (w_phase) begin
      if (w_timeout) state_d = S_ERR;
      else           timer_d = timer_q + 16'd1;
    end
  end

  assign w_buf_we    = w_fsm_we || ((state_q == S_IDLE) && buf_wr_en);
  assign w_buf_waddr = w_fsm_we ? idx_q : buf_wr_addr;
  assign w_buf_wdata = w_fsm_we ? datareceive : buf_wr_data;

  i2c_seq_buffer #(
    .DEPTH (MAX_BYTES),
    .AW    (LEN_W)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .we_i      (w_buf_we),
    .waddr_i   (w_buf_waddr),
    .wdata_i   (w_buf_wdata),
    .raddr_a_i (buf_rd_addr),
    .rdata_a_o (buf_rd_data),
    .raddr_b_i (idx_q),
    .rdata_b_o (w_buf_idx_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_i2c_reg_sequencer : randomized bench with a phase-list model of each command (rev 1.0)
// ============================================================================
module tb_i2c_reg_sequencer;

  localparam int MAXB  = 22;
  localparam int TMO   = 16;
  localparam int LW    = 5;
  localparam int NEVER = 1000;
  localparam int K_WAIT = 0, K_SEND = 1, K_WBUF = 2, K_RECV = 3, K_DONE = 4, K_ERR = 5;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0] cmd_reg = 8'h00;
  logic [LW-1:0] cmd_len = '0;
  logic buf_wr_en = 1'b0;
  logic [LW-1:0] buf_wr_addr = '0, buf_rd_addr = '0;
  logic [7:0] buf_wr_data = 8'h00, buf_rd_data;
  logic done, error, start, send, receive, last;
  logic isReady = 1'b0, sended = 1'b0, received = 1'b0;
  logic [7:0] datasend, datareceive = 8'h00;

  i2c_reg_sequencer #(.DEV_ADDR(7'h77), .MAX_BYTES(MAXB), .TIMEOUT(16'd16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .done(done), .error(error),
    .isReady(isReady), .start(start), .send(send), .datasend(datasend), .sended(sended),
    .receive(receive), .last(last), .datareceive(datareceive), .received(received));

  always #50 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         start;
    bit         last;
    int         bidx;
    int         delay;
    logic [7:0] rdata;
    bit         reject;
  } step_t;

  // Model: the buffer contents and the list of phases the current command still has to go through
  logic [7:0] mbuf [MAXB];
  step_t      steps [$];
  int age = 0, step_no = 0, cyc = 0;
  int n_checks = 0, n_fail = 0;

  int dmode = 3, hang_idx = -1;
  bit host_rand = 1'b0;
  bit hw_pend = 1'b0;
  logic [LW-1:0] hw_addr;
  logic [7:0] hw_data;
  bit pc_valid = 1'b0, pc_w = 1'b0;
  logic [7:0] pc_reg;
  int pc_len = 0;
  logic [7:0] pc_rdata [MAXB];

  logic [63:0] obs_bytes;
  logic [31:0] obs_start, obs_rlast;
  int n_recv, done_cnt, err_cnt, start_cnt, issue_cyc, err_cyc, reg_cyc;
  bit recv_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    obs_bytes = '0; obs_start = '0; obs_rlast = '0;
    n_recv = 0; done_cnt = 0; err_cnt = 0; start_cnt = 0;
    issue_cyc = 0; err_cyc = 0; reg_cyc = 0; recv_seen = 1'b0;
  endtask

  function automatic int pick_delay();
    return (dmode < 0) ? int'($urandom_range(0, 4)) : dmode;
  endfunction

  function automatic step_t mk(int kind, logic [7:0] data, bit st, bit lst, int bidx,
                               logic [7:0] rdata, bit rej);
    step_t s;
    s.kind = kind; s.data = data; s.start = st; s.last = lst;
    s.bidx = bidx; s.rdata = rdata; s.reject = rej;
    if (steps.size() == hang_idx)           s.delay = NEVER;
    else if (kind == K_WAIT && dmode >= 0)  s.delay = 0;
    else                                    s.delay = pick_delay();
    return s;
  endfunction

  function automatic void build(bit w, logic [7:0] r, int n);
    bit rej;
    rej = (n > MAXB) || (!w && n == 0);
    steps.delete();
    step_no = 0;
    age = 0;
    steps.push_back(mk(K_WAIT, 8'h00, 0, 0, 0, 8'h00, rej));
    if (rej) begin
      steps.push_back(mk(K_ERR, 8'h00, 0, 0, 0, 8'h00, 0));
      return;
    end
    steps.push_back(mk(K_SEND, {7'h77, 1'b0}, 1, 0, 0, 8'h00, 0));
    steps.push_back(mk(K_SEND, r, 0, (w && n == 0), 0, 8'h00, 0));
    if (w) begin
      for (int i = 0; i < n; i++) steps.push_back(mk(K_WBUF, 8'h00, 0, (i == n - 1), i, 8'h00, 0));
    end else begin
      steps.push_back(mk(K_SEND, {7'h77, 1'b1}, 1, 0, 0, 8'h00, 0));
      for (int i = 0; i < n; i++) steps.push_back(mk(K_RECV, 8'h00, 0, (i == n - 1), i, pc_rdata[i], 0));
    end
    steps.push_back(mk(K_DONE, 8'h00, 0, 0, 0, 8'h00, 0));
  endfunction

  // One clock cycle: compare DUT outputs against the model, then drive the next inputs
  task automatic tick();
    logic [14:0] e, a;
    logic e_rdy, e_dn, e_er, e_st, e_snd, e_rcv, e_lst;
    logic [7:0] e_ds, e_buf;
    bit adv, can_to;
    @(negedge clk);
    cyc++;
    e_rdy = 0; e_dn = 0; e_er = 0; e_st = 0; e_snd = 0; e_rcv = 0; e_lst = 0; e_ds = 8'h00;
    if (steps.size() == 0) e_rdy = 1;
    else begin
      case (steps[0].kind)
        K_SEND: begin e_snd = 1; e_st = steps[0].start; e_lst = steps[0].last; e_ds = steps[0].data; end
        K_WBUF: begin e_snd = 1; e_lst = steps[0].last; e_ds = mbuf[steps[0].bidx]; end
        K_RECV: begin e_rcv = 1; e_lst = steps[0].last; end
        K_DONE: e_dn = 1;
        K_ERR:  e_er = 1;
        default: ;
      endcase
    end
    e = {e_rdy, e_dn, e_er, e_st, e_snd, e_ds, e_rcv, e_lst};
    a = {cmd_ready, done, error, start, send, datasend, receive, last};
    check("outputs{rdy,done,err,start,send,data,recv,last}", 64'(a), 64'(e));
    e_buf = (int'(buf_rd_addr) < MAXB) ? mbuf[int'(buf_rd_addr)] : 8'h00;
    check("buf_rd_data", 64'(buf_rd_data), 64'(e_buf));
    if (done) done_cnt++;
    if (error) begin err_cnt++; err_cyc = cyc; end
    if (start) start_cnt++;
    if (receive) recv_seen = 1'b1;

    sended = 0; received = 0; buf_wr_en = 0; cmd_valid = 0;
    isReady = 1'($urandom); datareceive = 8'($urandom);
    cmd_write = 1'($urandom); cmd_reg = 8'($urandom); cmd_len = LW'($urandom);
    buf_rd_addr = LW'($urandom); buf_wr_addr = LW'($urandom); buf_wr_data = 8'($urandom);

    if (steps.size() == 0) begin
      if (hw_pend) begin
        buf_wr_en = 1; buf_wr_addr = hw_addr; buf_wr_data = hw_data; hw_pend = 0;
      end else if (host_rand && $urandom_range(0, 3) == 0) buf_wr_en = 1;
      if (buf_wr_en && int'(buf_wr_addr) < MAXB) mbuf[int'(buf_wr_addr)] = buf_wr_data;
      if (pc_valid && (dmode >= 0 || $urandom_range(0, 2) == 0)) begin
        cmd_valid = 1; cmd_write = pc_w; cmd_reg = pc_reg; cmd_len = LW'(pc_len);
        build(pc_w, pc_reg, pc_len);
        pc_valid = 0;
        issue_cyc = cyc;
      end
    end else begin
      // While busy: stray host traffic that must be ignored
      buf_wr_en = ($urandom_range(0, 3) == 0);
      cmd_valid = 1'($urandom);
      if (step_no == 2 && age == 0) reg_cyc = cyc;
      adv = 0; can_to = 0;
      case (steps[0].kind)
        K_WAIT: begin
          if (steps[0].reject) adv = 1;
          else begin isReady = (age >= steps[0].delay); adv = isReady; can_to = 1; end
        end
        K_SEND, K_WBUF: begin
          can_to = 1;
          if (age == steps[0].delay) begin
            sended = 1; adv = 1;
            obs_bytes = (obs_bytes << 8) | 64'(datasend);
            obs_start = (obs_start << 1) | 32'(start);
          end else if (steps[0].delay != NEVER && $urandom_range(0, 3) == 0) received = 1;
        end
        K_RECV: begin
          can_to = 1;
          if (age == steps[0].delay) begin
            received = 1; adv = 1; datareceive = steps[0].rdata;
            mbuf[steps[0].bidx] = steps[0].rdata;
            obs_rlast = (obs_rlast << 1) | 32'(last);
            n_recv++;
          end else if (steps[0].delay != NEVER && $urandom_range(0, 3) == 0) sended = 1;
        end
        default: adv = 1;
      endcase
      if (adv) begin
        void'(steps.pop_front()); age = 0; step_no++;
      end else if (can_to && age == TMO - 1) begin
        steps.delete();
        steps.push_back(mk(K_ERR, 8'h00, 0, 0, 0, 8'h00, 0));
        age = 0; step_no = 100;
      end else age++;
    end
  endtask

  task automatic run_cmd(input bit w, input logic [7:0] r, input int n);
    int guard;
    guard = 0;
    pc_valid = 1; pc_w = w; pc_reg = r; pc_len = n;
    do begin tick(); guard++; end while ((pc_valid || steps.size() != 0) && guard < 3000);
    check("cmd_completes_in_budget", 64'(guard < 3000), 64'd1);
  endtask

  task automatic host_write(input logic [LW-1:0] ad, input logic [7:0] d);
    hw_pend = 1; hw_addr = ad; hw_data = d;
    while (hw_pend) tick();
  endtask

  task automatic peek(input string name, input int ad, input logic [7:0] exp);
    buf_rd_addr = LW'(ad);
    #1;
    check(name, 64'(buf_rd_data), 64'(exp));
  endtask

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    for (int i = 0; i < MAXB; i++) mbuf[i] = 8'h00;
    clear_obs();
    #1;
    check("reset_outputs", 64'({cmd_ready, done, error, start, send, datasend, receive, last}), 64'h4000);
    check("reset_buf0", 64'(buf_rd_data), 64'h0);
    @(negedge clk);
    reset = 0;

    // Chip ID read
    dmode = 3; clear_obs();
    pc_rdata[0] = 8'h55;
    run_cmd(1'b0, 8'hD0, 1);
    check("chipid_bytes", obs_bytes, 64'hEED0EF);
    check("chipid_start", 64'(obs_start), 64'h5);
    check("chipid_last_on_read", 64'(obs_rlast), 64'h1);
    check("chipid_done_cnt", 64'(done_cnt), 64'd1);
    check("chipid_err_cnt", 64'(err_cnt), 64'd0);
    peek("chipid_buf0", 0, 8'h55);

    // Burst read of 22 bytes
    clear_obs();
    for (int i = 0; i < MAXB; i++) pc_rdata[i] = 8'(i);
    run_cmd(1'b0, 8'hAA, 22);
    check("burst_bytes", obs_bytes, 64'hEEAAEF);
    check("burst_nrecv", 64'(n_recv), 64'd22);
    check("burst_last_only_final", 64'(obs_rlast), 64'h1);
    check("burst_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < MAXB; i++) peek("burst_buf", i, 8'(i));

    // Register write
    host_write(5'd0, 8'h2E);
    clear_obs();
    run_cmd(1'b1, 8'hF4, 1);
    check("write_bytes", obs_bytes, 64'hEEF42E);
    check("write_start", 64'(obs_start), 64'h4);
    check("write_no_receive", 64'(recv_seen), 64'd0);
    check("write_done_cnt", 64'(done_cnt), 64'd1);
    peek("write_buf0_kept", 0, 8'h2E);

    // Timeout while the master stalls on the register byte
    clear_obs(); hang_idx = 2;
    run_cmd(1'b0, 8'h12, 2);
    hang_idx = -1;
    check("timeout_latency", 64'(err_cyc - reg_cyc), 64'd16);
    check("timeout_err_cnt", 64'(err_cnt), 64'd1);
    check("timeout_done_cnt", 64'(done_cnt), 64'd0);

    // Rejected commands
    clear_obs();
    run_cmd(1'b0, 8'h20, 0);
    check("reject_len0_latency", 64'(err_cyc - issue_cyc), 64'd2);
    check("reject_len0_err_cnt", 64'(err_cnt), 64'd1);
    clear_obs();
    run_cmd(1'b1, 8'h21, 23);
    check("reject_len23_latency", 64'(err_cyc - issue_cyc), 64'd2);
    check("reject_no_start", 64'(start_cnt), 64'd0);
    peek("reject_buf0_kept", 0, 8'h2E);

    // Randomized commands, stalls and stray host traffic
    dmode = -1; host_rand = 1;
    for (int t = 0; t < 40; t++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(23, 31)) : int'($urandom_range(0, 22));
      hang_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n + 3)) : -1;
      for (int i = 0; i < MAXB; i++) pc_rdata[i] = 8'($urandom);
      run_cmd(1'($urandom_range(0, 1)), 8'($urandom), n);
    end
    hang_idx = -1;

    // Asynchronous reset in the middle of a burst read
    for (int i = 0; i < MAXB; i++) pc_rdata[i] = 8'($urandom) | 8'h01;
    pc_valid = 1; pc_w = 0; pc_reg = 8'h33; pc_len = 22;
    guard = 0;
    do begin tick(); guard++; end
    while (!(steps.size() > 0 && steps[0].kind == K_RECV && steps[0].bidx == 5) && guard < 3000);
    check("reached_byte5", 64'(guard < 3000), 64'd1);
    @(posedge clk);
    #5;
    check("pre_reset_receive", 64'(receive), 64'd1);
    reset = 1;
    #1;
    check("async_reset_outputs", 64'({cmd_ready, done, error, start, send, datasend, receive, last}), 64'h4000);
    for (int i = 0; i < MAXB; i++) begin
      buf_rd_addr = LW'(i);
      #1;
      check("async_reset_buf", 64'(buf_rd_data), 64'h0);
    end
    @(negedge clk);
    reset = 0; sended = 0; received = 0; cmd_valid = 0; buf_wr_en = 0;
    steps.delete(); age = 0; pc_valid = 0;
    for (int i = 0; i < MAXB; i++) mbuf[i] = 8'h00;

    // Recovery after reset
    dmode = 3; host_rand = 0; clear_obs();
    pc_rdata[0] = 8'hC3;
    run_cmd(1'b0, 8'hD0, 1);
    check("recover_done_cnt", 64'(done_cnt), 64'd1);
    peek("recover_buf0", 0, 8'hC3);
    peek("recover_buf1", 1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Parametrised I2C register-transaction sequencer that sits between a host controller and the byte-level I2C master. It is the generic successor to the hard-wired BMP180 chip-ID reader. It accepts a command (device register, direction, burst length) and drives the master's start/send/receive handshake. It also holds a buffer of up to `MAX_BYTES` write or read bytes, and adds a timeout abort and a done/error report.

## Interface
- `DEV_ADDR`, 7'h77, 7-bit I2C device address
- `MAX_BYTES`, 22, buffer depth and maximum burst length (≥2)
- `TIMEOUT`, 16'hFFFF, maximum cycles to wait for a `sended`/`received` pulse
- `LEN_W`, $clog2(MAX_BYTES+1), width of length field
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high in IDLE
- `cmd_write`  in  1  1 = register write, 0 = register read
- `cmd_reg`  in  8  register address
- `cmd_len`  in  LEN_W  data bytes, 0..MAX_BYTES
- `buf_wr_en`, `buf_wr_addr`[LEN_W], `buf_wr_data`[8]  in  host buffer load, honoured only in IDLE
- `buf_rd_addr`  in  LEN_W; `buf_rd_data`  out  8  combinational buffer read, 0 when address ≥ MAX_BYTES
- `done`  out  1  one-cycle pulse on successful completion
- `error`  out  1  one-cycle pulse on reject or timeout
- `isReady`  in  1  I2C master idle
- `start`  out  1  generate START/RESTART before current byte
- `send`  out  1  byte on `datasend` is valid
- `datasend`  out  8  byte to transmit; 0 when `send`=0
- `sended`  in  1  one-cycle pulse: master consumed `datasend`
- `receive`  out  1  request one byte from slave
- `last`  out  1  current byte is final (master NACKs read, issues STOP)
- `datareceive`  in  8; `received`  in  1  one-cycle pulse, byte valid

## Operation
- States: IDLE, WAIT_READY, ADDR_W, REG, DATA_W, ADDR_R, DATA_R, DONE, ERR.
- IDLE: `cmd_valid`&&`cmd_ready` latches the command and clears byte index `idx`.
- Reject: `cmd_len` > MAX_BYTES, or a read with `cmd_len`=0, goes to ERR.
- WAIT_READY: waits for `isReady`, then goes to ADDR_W.
- ADDR_W: `start`=1, `datasend`={DEV_ADDR,1'b0}. On `sended`, goes to REG.
- REG: `datasend`=`cmd_reg`.
  - On `sended`, a read goes to ADDR_R.
  - A write with len=0 goes to DONE, with `last`=1 during REG.
  - Any other write goes to DATA_W.
- DATA_W: `datasend`=buf[idx]; `last`=(idx==len-1). On `sended`, idx++; after the last byte, goes to DONE.
- ADDR_R: `start`=1 (RESTART), `datasend`={DEV_ADDR,1'b1}. On `sended`, goes to DATA_R.
- DATA_R: `receive`=1, `last`=(idx==len-1). On `received`, buf[idx]←`datareceive`, idx++; after the last byte, goes to DONE.
- DONE: pulses `done`, then IDLE. ERR: pulses `error`, then IDLE.
- `send` is 1 exactly in ADDR_W, REG, DATA_W, ADDR_R. `receive` is 1 only in DATA_R.
- `sended` outside a send state and `received` outside DATA_R are ignored.
- Timeout: a counter reloads on entry to each byte phase and on each handshake pulse. Reaching TIMEOUT in any phase from WAIT_READY through DATA_R goes to ERR. Outputs drop in the ERR cycle and `buf` keeps the bytes received so far.
- Host buffer writes outside IDLE are dropped. `buf_rd_data` is readable at all times.

## Timing
- Reset (asynchronous, any state): state=IDLE, idx=0, timer=0, buffer cleared to 0.
  - `cmd_ready`=1; all other outputs 0.
- Command accepted at edge T gives WAIT_READY at T+1. If `isReady` is high at T+1, ADDR_W outputs appear at T+2.
- A handshake pulse sampled at edge N advances the state. The next byte, or deassertion, is visible after edge N.
- Read data is written to the buffer on the same edge as `received`. It is visible on `buf_rd_data` the following cycle.
- `done`/`error` go high exactly one cycle after the final pulse or the timeout. `cmd_ready` returns the cycle after that.
- `cmd_valid` held through DONE is accepted again only in IDLE. There is no back-to-back accept in the DONE cycle.

## Structure
- Package `i2c_seq_pkg` holds:
  - state enum
  - `I2C_READ`/`I2C_WRITE` bit constants
  - default `DEV_ADDR`
  - `MAX_BYTES` and `TIMEOUT` defaults
- Sub-module `i2c_seq_buffer`: MAX_BYTES×8 register file with asynchronous clear, one write port (host or FSM, muxed) and a combinational read port.
- The FSM, timeout counter and output decode stay in `i2c_reg_sequencer`.

## Test plan
- Chip ID read: reg=8'hD0, len=1, `isReady`=1, master pulses each handshake 3 cycles after the request, returns 8'h55. Required:
  - `datasend` sequence EE, D0, EF.
  - `start` high on EE and EF.
  - `last`=1 in DATA_R.
  - buf[0]=55; `done` pulse; no `error`.
- Burst read: reg=8'hAA, len=22, slave bytes 8'h00..8'h15. Required: buf[i]=i; `last` only on byte 21; single `done`.
- Write: host loads buf[0]=8'h2E, then cmd_write=1, reg=8'hF4, len=1. Required: `datasend` EE, F4, 2E; `start` only on EE; `receive` never 1; `done`.
- Timeout: TIMEOUT=16, the master never pulses `sended` in REG. Required: `error` pulse 16 cycles after REG entry; `send`=0; `cmd_ready`=1 next cycle.
- Reject: read with len=0, then len=23. Required: `error` one cycle after WAIT_READY entry, no `start`; host `buf_wr_en` during a busy transfer leaves the buffer unchanged.
- Reset mid-burst: assert `reset` during DATA_R byte 5. Required: all outputs 0, `cmd_ready`=1, buffer all 0 immediately (asynchronous), before the next clock edge.
